// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: request/response handshake plus memory strobe bundle.
// master = requester and memory side, slave = the controller.
interface mem_access_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic ReqValid;
  logic ReqReady;
  logic ReqWrite;
  logic [ADDR_W-1:0] ReqAddr;
  logic [DATA_W-1:0] ReqWData;
  logic RspValid;
  logic [DATA_W-1:0] RspData;
  logic RspErr;
  logic Busy;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWData;
  logic MemRead;
  logic MemWrite;
  logic [DATA_W-1:0] MemRData;
  modport master (
    output ReqValid, ReqWrite, ReqAddr, ReqWData, MemRData,
    input ReqReady, RspValid, RspData, RspErr, Busy, MemAddr, MemWData, MemRead, MemWrite
  );
  modport slave (
    input ReqValid, ReqWrite, ReqAddr, ReqWData, MemRData,
    output ReqReady, RspValid, RspData, RspErr, Busy, MemAddr, MemWData, MemRead, MemWrite
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding load/store initiator for the 16-bit data memory,
// sequencing MemRead/MemWrite with the memory read latency and returning a one-cycle response.
module mem_access_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int READ_LATENCY = 1,
  parameter int CHECK_ALIGN = 1
) (
  input logic CLK,
  input logic Reset_n,
  mem_access_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MEM_WR, MEM_RD, RESP} state_t;
  state_t state, stateNext;
  logic [2:0] cnt, cntNext;
  logic reqReady, rspValid, rspErr, rspErrNext, busy, memRead, memWrite;
  logic [DATA_W-1:0] rspData, rspDataNext, memWData, memWDataNext;
  logic [ADDR_W-1:0] memAddr, memAddrNext;
  assign bus.ReqReady = reqReady;
  assign bus.RspValid = rspValid;
  assign bus.RspData = rspData;
  assign bus.RspErr = rspErr;
  assign bus.Busy = busy;
  assign bus.MemAddr = memAddr;
  assign bus.MemWData = memWData;
  assign bus.MemRead = memRead;
  assign bus.MemWrite = memWrite;
  always_comb begin
    stateNext = state;
    cntNext = cnt;
    rspDataNext = rspData;
    rspErrNext = rspErr;
    memAddrNext = memAddr;
    memWDataNext = memWData;
    case (state)
      IDLE:
        if (bus.ReqValid && reqReady) begin
          if ((CHECK_ALIGN != 0) && bus.ReqAddr[0]) begin
            stateNext = RESP;
            rspErrNext = 1'b1;
            rspDataNext = '0;
          end else if (bus.ReqWrite) begin
            stateNext = MEM_WR;
            memAddrNext = bus.ReqAddr;
            memWDataNext = bus.ReqWData;
          end else begin
            stateNext = MEM_RD;
            memAddrNext = bus.ReqAddr;
            cntNext = 3'(READ_LATENCY - 1);
          end
        end
      MEM_WR: begin
        stateNext = RESP;
        rspDataNext = memWData;
        rspErrNext = 1'b0;
      end
      MEM_RD:
        if (cnt == '0) begin
          stateNext = RESP;
          rspDataNext = bus.MemRData;
          rspErrNext = 1'b0;
        end else cntNext = cnt - 3'd1;
      default: stateNext = IDLE;
    endcase
  end
  // Every output flag is a registered decode of the next state, so strobes and pulses align with state.
  always_ff @(posedge CLK or negedge Reset_n)
    if (!Reset_n) begin
      state <= IDLE;
      cnt <= '0;
      reqReady <= 1'b0;
      busy <= 1'b0;
      rspValid <= 1'b0;
      rspErr <= 1'b0;
      memRead <= 1'b0;
      memWrite <= 1'b0;
      rspData <= '0;
      memAddr <= '0;
      memWData <= '0;
    end else begin
      state <= stateNext;
      cnt <= cntNext;
      reqReady <= stateNext == IDLE;
      busy <= stateNext != IDLE;
      rspValid <= stateNext == RESP;
      memRead <= stateNext == MEM_RD;
      memWrite <= stateNext == MEM_WR;
      rspErr <= rspErrNext;
      rspData <= rspDataNext;
      memAddr <= memAddrNext;
      memWData <= memWDataNext;
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench driving a READ_LATENCY=1 and a READ_LATENCY=3 controller
// against a simple combinational-read memory model.
module tb_mem_access_ctrl;
  typedef struct {
    int g;
    logic [15:0] data;
    logic err;
    int due;
  } rsp_t;
  logic clk = 1'b0;
  logic [1:0] rstN;
  logic reqValid[2], reqWrite[2], reqReady[2], rspValid[2], rspErr[2], busy[2], memRead[2], memWrite[2];
  logic [15:0] reqAddr[2], reqWData[2], rspData[2], memAddr[2], memWData[2];
  logic [15:0] expAddr[2], expWData[2];
  logic [15:0] refMem[int];
  int lat[2] = '{1, 3};
  int rdLen[2], wrLen[2], strobes[2];
  int cyc = 0;
  int nChecks = 0, nErrors = 0;
  rsp_t sb[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 0; g < 2; g++) begin : gInst
    logic [15:0] mem [256];
    mem_access_ctrl_if bus ();
    mem_access_ctrl #(.READ_LATENCY(g == 0 ? 1 : 3)) dut (.CLK(clk), .Reset_n(rstN[g]), .bus(bus));
    assign bus.ReqValid = reqValid[g];
    assign bus.ReqWrite = reqWrite[g];
    assign bus.ReqAddr = reqAddr[g];
    assign bus.ReqWData = reqWData[g];
    assign bus.MemRData = bus.MemRead ? mem[bus.MemAddr[8:1]] : 16'hDEAD;
    assign reqReady[g] = bus.ReqReady;
    assign rspValid[g] = bus.RspValid;
    assign rspData[g] = bus.RspData;
    assign rspErr[g] = bus.RspErr;
    assign busy[g] = bus.Busy;
    assign memAddr[g] = bus.MemAddr;
    assign memWData[g] = bus.MemWData;
    assign memRead[g] = bus.MemRead;
    assign memWrite[g] = bus.MemWrite;
    initial for (int i = 0; i < 256; i++) mem[i] = '0;
    always @(posedge clk) if (bus.MemWrite) mem[bus.MemAddr[8:1]] <= bus.MemWData;
  end
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, act, exp, cyc);
    end
  endtask
  function automatic logic [63:0] outs(input int g);
    return {10'b0, reqReady[g], rspValid[g], rspErr[g], busy[g], memRead[g], memWrite[g],
            rspData[g], memAddr[g], memWData[g]};
  endfunction
  always @(negedge clk)
    for (int g = 0; g < 2; g++)
      if (!rstN[g]) begin
        rdLen[g] = 0;
        wrLen[g] = 0;
      end else begin
        rsp_t e;
        check($sformatf("excl%0d", g), {63'b0, memRead[g] & memWrite[g]}, 0);
        check($sformatf("readyBusy%0d", g), {63'b0, reqReady[g] & busy[g]}, 0);
        if (memRead[g]) begin
          if (rdLen[g] == 0) strobes[g]++;
          rdLen[g]++;
          check($sformatf("rdAddr%0d", g), memAddr[g], expAddr[g]);
        end else if (rdLen[g] != 0) begin
          check($sformatf("rdLen%0d", g), rdLen[g], lat[g]);
          rdLen[g] = 0;
        end
        if (memWrite[g]) begin
          if (wrLen[g] == 0) strobes[g]++;
          wrLen[g]++;
          check($sformatf("wrAddr%0d", g), memAddr[g], expAddr[g]);
          check($sformatf("wrData%0d", g), memWData[g], expWData[g]);
        end else if (wrLen[g] != 0) begin
          check($sformatf("wrLen%0d", g), wrLen[g], 1);
          wrLen[g] = 0;
        end
        if (rspValid[g]) begin
          if (sb.size() == 0) check($sformatf("spuriousRsp%0d", g), {63'b0, rspValid[g]}, 0);
          else begin
            e = sb.pop_front();
            check("rspInst", g, e.g);
            check($sformatf("rspData%0d", g), rspData[g], e.data);
            check($sformatf("rspErr%0d", g), {63'b0, rspErr[g]}, {63'b0, e.err});
            check($sformatf("rspCycle%0d", g), cyc, e.due);
          end
        end
      end
  task automatic doReq(input int g, input logic wr, input logic [15:0] a, input logic [15:0] d);
    rsp_t e;
    int n = 0;
    int key = g * 65536 + int'(a);
    @(negedge clk);
    reqValid[g] = 1'b1;
    reqWrite[g] = wr;
    reqAddr[g] = a;
    reqWData[g] = d;
    while (!reqReady[g] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!reqReady[g]) begin
      check("acceptTimeout", {63'b0, reqReady[g]}, 1);
      reqValid[g] = 1'b0;
      return;
    end
    expAddr[g] = a;
    if (wr && !a[0]) expWData[g] = d;
    e.g = g;
    e.err = a[0];
    e.data = a[0] ? 16'h0000 : wr ? d : (refMem.exists(key) ? refMem[key] : 16'h0000);
    e.due = cyc + 1 + (a[0] ? 0 : wr ? 1 : lat[g]);
    if (wr && !a[0]) refMem[key] = d;
    sb.push_back(e);
    @(posedge clk);
    #1 reqValid[g] = 1'b0;
  endtask
  task automatic waitRsp();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) check("rspTimeout", sb.size(), 0);
    sb.delete();
  endtask
  initial begin
    int s;
    rstN = 2'b00;
    for (int g = 0; g < 2; g++) begin
      reqValid[g] = 1'b0;
      reqWrite[g] = 1'b0;
      reqAddr[g] = '0;
      reqWData[g] = '0;
      expAddr[g] = '0;
      expWData[g] = '0;
    end
    repeat (3) begin
      @(negedge clk);
      check("resetOuts0", outs(0), 0);
      check("resetOuts1", outs(1), 0);
    end
    rstN = 2'b11;
    #1 check("readyBeforeEdge", {63'b0, reqReady[0]}, 0);
    @(negedge clk);
    check("readyAfterRelease", {62'b0, reqReady[0], reqReady[1]}, 3);
    doReq(0, 1'b1, 16'h0000, 16'h0000);
    waitRsp();
    doReq(0, 1'b0, 16'h0000, 16'h1111);
    waitRsp();
    doReq(0, 1'b1, 16'h0002, 16'hFFFF);
    doReq(0, 1'b0, 16'h0002, 16'h0000);
    waitRsp();
    s = strobes[0];
    doReq(0, 1'b0, 16'h0003, 16'h0000);
    doReq(0, 1'b1, 16'h0005, 16'hBEEF);
    waitRsp();
    check("errNoStrobe", strobes[0], s);
    doReq(0, 1'b1, 16'hFFFE, 16'h1234);
    doReq(0, 1'b0, 16'hFFFE, 16'h0000);
    waitRsp();
    for (int i = 0; i < 10; i++) doReq(0, 1'($urandom_range(0, 1)), 16'($urandom_range(1, 100) * 2), 16'($urandom));
    waitRsp();
    doReq(1, 1'b1, 16'h0002, 16'hFFFF);
    doReq(1, 1'b0, 16'h0002, 16'h0000);
    waitRsp();
    s = strobes[1];
    doReq(1, 1'b0, 16'h0003, 16'h0000);
    waitRsp();
    check("errNoStrobe3", strobes[1], s);
    doReq(1, 1'b0, 16'h0002, 16'h0000);
    @(posedge clk);
    #2 rstN[1] = 1'b0;
    #1 check("midRstRead", {62'b0, memRead[1], busy[1]}, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    check("midRstNoRsp", {63'b0, rspValid[1]}, 0);
    rstN[1] = 1'b1;
    @(negedge clk);
    check("readyAfterMidRst", {63'b0, reqReady[1]}, 1);
    doReq(1, 1'b0, 16'h0002, 16'h0000);
    waitRsp();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
